// File: rtl/rmw_counter_bank.sv
// rmw_counter_bank: bank of DEPTH read-modify-write counters with forwarding, wrap/saturate, read port and bulk clear
// Ports: clk, reset (async, active-low); io_inc_valid/ready/addr/amt increment request;
// io_clr/io_busy bulk clear; io_rd_addr/io_rd_data registered read; io_upd_valid/addr/data/io_ovf commit report.
module rmw_counter_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int INC_W    = 8,
  parameter int SATURATE = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_inc_valid,
  output logic             io_inc_ready,
  input  logic [AW-1:0]    io_inc_addr,
  input  logic [INC_W-1:0] io_inc_amt,
  input  logic             io_clr,
  output logic             io_busy,
  input  logic [AW-1:0]    io_rd_addr,
  output logic [WIDTH-1:0] io_rd_data,
  output logic             io_upd_valid,
  output logic [AW-1:0]    io_upd_addr,
  output logic [WIDTH-1:0] io_upd_data,
  output logic             io_ovf
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] idx, s1_addr, wa;
  logic [INC_W-1:0] s1_amt;
  logic s1_valid, accept, we, ovf;
  logic [WIDTH-1:0] rd_q, base, res, wd;
  logic [WIDTH:0] sum;
  assign io_inc_ready = (state == IDLE) && !io_clr;
  assign io_busy = (state == CLEAR);
  // the op committed at the previous edge is not yet in rd_q, so take it from the update register
  always_comb begin
    accept = io_inc_valid & io_inc_ready;
    base = (io_upd_valid && io_upd_addr == s1_addr) ? io_upd_data : rd_q;
    sum = {1'b0, base} + (WIDTH+1)'(s1_amt);
    ovf = sum[WIDTH];
    res = (SATURATE != 0 && ovf) ? '1 : sum[WIDTH-1:0];
    we = s1_valid | (state == CLEAR);
    wa = s1_valid ? s1_addr : idx;
    wd = s1_valid ? res : '0;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[io_inc_addr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      idx <= '0;
      s1_valid <= 1'b0;
      s1_addr <= '0;
      s1_amt <= '0;
      io_rd_data <= '0;
      io_upd_valid <= 1'b0;
      io_upd_addr <= '0;
      io_upd_data <= '0;
      io_ovf <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_addr <= io_inc_addr;
      s1_amt <= io_inc_amt;
      io_rd_data <= mem[io_rd_addr];
      io_upd_valid <= s1_valid;
      io_ovf <= s1_valid & ovf;
      if (s1_valid) begin
        io_upd_addr <= s1_addr;
        io_upd_data <= res;
      end
      // a pending S1 write owns the port; the sweep holds its index that cycle
      if (state == CLEAR && !s1_valid) begin
        idx <= idx + 1'b1;
        if (idx == AW'(DEPTH-1)) state <= IDLE;
      end else if (state == IDLE && io_clr) begin
        state <= CLEAR;
        idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rmw_counter_bank.sv
// tb_rmw_counter_bank: scoreboard bench running a wrapping and a saturating bank on shared stimulus
module tb_rmw_counter_bank;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic io_inc_valid = 1'b0, io_clr = 1'b0;
  logic [2:0] io_inc_addr = '0, io_rd_addr = '0;
  logic [7:0] io_inc_amt = '0;
  logic rdy0, rdy1, busy0, busy1, uv0, uv1, ov0, ov1;
  logic [2:0] ua0, ua1;
  logic [7:0] rdd0, rdd1, ud0, ud1;
  int checks = 0, errors = 0;
  typedef struct packed {logic [2:0] a; logic [7:0] d; logic o;} exp_t;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  rmw_counter_bank #(.WIDTH(8), .DEPTH(8), .INC_W(8), .SATURATE(0)) d0 (
    .clk(clk), .reset(reset), .io_inc_valid(io_inc_valid), .io_inc_ready(rdy0),
    .io_inc_addr(io_inc_addr), .io_inc_amt(io_inc_amt), .io_clr(io_clr), .io_busy(busy0),
    .io_rd_addr(io_rd_addr), .io_rd_data(rdd0), .io_upd_valid(uv0), .io_upd_addr(ua0),
    .io_upd_data(ud0), .io_ovf(ov0));
  rmw_counter_bank #(.WIDTH(8), .DEPTH(8), .INC_W(8), .SATURATE(1)) d1 (
    .clk(clk), .reset(reset), .io_inc_valid(io_inc_valid), .io_inc_ready(rdy1),
    .io_inc_addr(io_inc_addr), .io_inc_amt(io_inc_amt), .io_clr(io_clr), .io_busy(busy1),
    .io_rd_addr(io_rd_addr), .io_rd_data(rdd1), .io_upd_valid(uv1), .io_upd_addr(ua1),
    .io_upd_data(ud1), .io_ovf(ov1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic pop_cmp(input string n, inout exp_t q[$], input logic [2:0] a, input logic [7:0] d, input logic o);
    exp_t e;
    if (q.size() == 0) chk({n, "_unexpected_upd"}, 1, 0);
    else begin
      e = q.pop_front();
      chk({n, "_upd_addr"}, a, e.a);
      chk({n, "_upd_data"}, d, e.d);
      chk({n, "_ovf"}, o, e.o);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (uv0) pop_cmp("d0", q0, ua0, ud0, ov0);
      if (uv1) pop_cmp("d1", q1, ua1, ud1, ov1);
    end
  endtask
  task automatic inc(input logic [2:0] a, input logic [7:0] amt, input logic [7:0] e0, input logic [7:0] e1, input logic o0, input logic o1);
    io_inc_valid = 1'b1;
    io_inc_addr = a;
    io_inc_amt = amt;
    q0.push_back('{a, e0, o0});
    q1.push_back('{a, e1, o1});
    chk("inc_ready0", rdy0, 1);
    chk("inc_ready1", rdy1, 1);
    @(posedge clk);
    #1 io_inc_valid = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [7:0] e0, input logic [7:0] e1);
    io_rd_addr = a;
    @(posedge clk);
    #1;
    chk($sformatf("rd0_addr%0d", a), rdd0, e0);
    chk($sformatf("rd1_addr%0d", a), rdd1, e1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!rdy0 && n < 40);
    chk("ready_latency", n, 8);
    chk("ready1_match", rdy1, 1);
    chk("busy_after_sweep", busy0, 0);
  endtask
  initial begin
    logic [2:0] seq_a [4];
    logic [7:0] seq_e [4];
    int n;
    fork monitor(); join_none
    io_inc_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_ready();
    q0.push_back('{3'd0, 8'd0, 1'b0});
    q1.push_back('{3'd0, 8'd0, 1'b0});
    @(posedge clk);
    #1 io_inc_valid = 1'b0;
    idle(2);
    for (int i = 0; i < 8; i++) rd(3'(i), 0, 0);
    inc(3, 5, 5, 5, 0, 0);
    inc(3, 7, 12, 12, 0, 0);
    idle(2);
    for (int i = 0; i < 8; i++) rd(3'(i), (i == 3) ? 8'd12 : 8'd0, (i == 3) ? 8'd12 : 8'd0);
    inc(1, 250, 250, 250, 0, 0);
    inc(1, 10, 4, 255, 1, 1);
    inc(1, 1, 5, 255, 0, 1);
    idle(2);
    rd(1, 5, 255);
    seq_a = '{3'd2, 3'd2, 3'd5, 3'd2};
    seq_e = '{8'd1, 8'd2, 8'd1, 8'd3};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        io_inc_valid = 1'b1;
        io_inc_addr = seq_a[i];
        io_inc_amt = 8'd1;
        q0.push_back('{seq_a[i], seq_e[i], 1'b0});
        q1.push_back('{seq_a[i], seq_e[i], 1'b0});
      end else io_inc_valid = 1'b0;
      @(posedge clk);
      #1 chk($sformatf("upd_pulse_cycle%0d", i), uv0, (i >= 1 && i <= 4) ? 1 : 0);
    end
    idle(1);
    rd(2, 3, 3);
    rd(5, 1, 1);
    io_clr = 1'b1;
    io_inc_valid = 1'b1;
    io_inc_addr = 3'd6;
    io_inc_amt = 8'd3;
    #1 chk("clr_blocks_ready", rdy0, 0);
    @(posedge clk);
    #1 io_clr = 1'b0;
    io_inc_valid = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("clr_busy_cycles", n, 8);
    for (int i = 0; i < 8; i++) rd(3'(i), 0, 0);
    io_inc_valid = 1'b1;
    io_inc_addr = 3'd4;
    io_inc_amt = 8'd9;
    @(posedge clk);
    #1 io_inc_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_upd_valid", uv0, 0);
    chk("rst_upd_data", ud0, 0);
    chk("rst_upd_addr", ua0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_rd_data", rdd0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_ready();
    idle(1);
    rd(4, 0, 0);
    idle(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
